// File: rtl/stack_word_exec_pkg.sv
// Shared opcode encoding, FSM state codes and per-opcode micro-sequence
// tables for the stack word executor.
package stack_word_exec_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_PUSH = 4'd0,
        OP_DROP = 4'd1,
        OP_DUP  = 4'd2,
        OP_SWAP = 4'd3,
        OP_OVER = 4'd4,
        OP_ROT  = 4'd5,
        OP_PICK = 4'd6,
        OP_TOP  = 4'd7
    } stack_op_t;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ISSUE = 3'd1;
    localparam logic [2:0] S_RD_CAP   = 3'd2;
    localparam logic [2:0] S_WR       = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    function automatic logic [1:0] op_reads(input logic [OP_W-1:0] op);
        logic [1:0] n;
        n = 2'd0;
        case (op)
            OP_DUP, OP_OVER, OP_PICK, OP_TOP: n = 2'd1;
            OP_SWAP:                          n = 2'd2;
            OP_ROT:                           n = 2'd3;
            default:                          n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] op_writes(input logic [OP_W-1:0] op);
        logic [1:0] n;
        n = 2'd0;
        case (op)
            OP_PUSH, OP_DROP, OP_DUP, OP_OVER, OP_PICK: n = 2'd1;
            OP_SWAP:                                    n = 2'd2;
            OP_ROT:                                     n = 2'd3;
            default:                                    n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic op_has_result(input logic [OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_DUP, OP_OVER, OP_PICK, OP_TOP: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stack_word_exec_if.sv
// Command/result port between an instruction decoder (master) and the
// stack word executor (slave).
interface stack_word_exec_if #(
    parameter int WIDTH = 8
) ();
    import stack_word_exec_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [WIDTH-1:0]  cmd_data;
    logic              res_valid;
    logic [WIDTH-1:0]  res_data;
    logic              res_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, res_valid, res_data, res_err
    );

endinterface

// File: rtl/stack_word_exec.sv
// Executes Forth-style stack words as peek/push/pop/poke micro-sequences
// against an attached stack; one command in flight, errors leave the stack untouched.
//
// state      | meaning
// S_IDLE     | ready for a command; depth/full checked on accept
// S_RD_ISSUE | peek strobe for operand k
// S_RD_CAP   | capture stack read data into operand k
// S_WR       | one push/pop/poke per cycle, write k
// S_DONE     | one-cycle result pulse
module stack_word_exec
    import stack_word_exec_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int IW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    stack_word_exec_if.slave  cmd,
    output logic              st_push_en,
    output logic              st_pop_en,
    output logic              st_peek_en,
    output logic              st_poke_en,
    output logic [WIDTH-1:0]  st_data_in,
    output logic [IW-1:0]     st_index,
    input  logic [WIDTH-1:0]  st_data_out,
    input  logic              st_full,
    input  logic [IW-1:0]     st_depth
);

    localparam logic [IW-1:0] D1 = IW'(1);
    localparam logic [IW-1:0] D2 = IW'(2);
    localparam logic [IW-1:0] D3 = IW'(3);

    state_t           state;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] imm_q;
    logic [IW-1:0]    n_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [1:0]       k_q;
    logic             err_q;

    logic [1:0]       n_reads;
    logic [1:0]       n_writes;
    logic [IW-1:0]    pick_n;
    logic             cmd_err;
    logic [IW-1:0]    rd_index;

    logic             push_en, pop_en, peek_en, poke_en;
    logic [WIDTH-1:0] data_in;
    logic [IW-1:0]    index;
    logic             res_valid, res_err;
    logic [WIDTH-1:0] res_data;

    assign n_reads  = op_reads(op_q);
    assign n_writes = op_writes(op_q);
    assign pick_n   = IW'(cmd.cmd_data);

    // PICK n >= DEPTH can never satisfy depth > n, so it falls out as underflow.
    always_comb begin
        cmd_err = 1'b0;
        case (cmd.cmd_op)
            OP_PUSH:         cmd_err = st_full;
            OP_DROP, OP_TOP: cmd_err = (st_depth < D1);
            OP_DUP:          cmd_err = (st_depth < D1) || st_full;
            OP_OVER:         cmd_err = (st_depth < D2) || st_full;
            OP_PICK:         cmd_err = !(st_depth > pick_n) || st_full;
            OP_SWAP:         cmd_err = (st_depth < D2);
            OP_ROT:          cmd_err = (st_depth < D3);
            default:         cmd_err = 1'b1;
        endcase
    end

    always_comb begin
        rd_index = IW'(k_q);
        case (op_q)
            OP_OVER: rd_index = D1;
            OP_PICK: rd_index = n_q;
            default: rd_index = IW'(k_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_q  <= '0;
            imm_q <= '0;
            n_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            k_q   <= 2'd0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_q  <= cmd.cmd_op;
                        imm_q <= cmd.cmd_data;
                        n_q   <= pick_n;
                        k_q   <= 2'd0;
                        err_q <= cmd_err;
                        if (cmd_err)
                            state <= S_DONE;
                        else if (op_reads(cmd.cmd_op) != 2'd0)
                            state <= S_RD_ISSUE;
                        else
                            state <= S_WR;
                    end
                end
                S_RD_ISSUE: state <= S_RD_CAP;
                S_RD_CAP: begin
                    case (k_q)
                        2'd0:    a_q <= st_data_out;
                        2'd1:    b_q <= st_data_out;
                        default: c_q <= st_data_out;
                    endcase
                    if (k_q == n_reads - 2'd1) begin
                        k_q   <= 2'd0;
                        state <= (n_writes != 2'd0) ? S_WR : S_DONE;
                    end else begin
                        k_q   <= k_q + 2'd1;
                        state <= S_RD_ISSUE;
                    end
                end
                S_WR: begin
                    if (k_q == n_writes - 2'd1) begin
                        k_q   <= 2'd0;
                        state <= S_DONE;
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Poke indices are taken against the unchanged depth, so SWAP/ROT rewrite in place.
    always_comb begin
        push_en   = 1'b0;
        pop_en    = 1'b0;
        peek_en   = 1'b0;
        poke_en   = 1'b0;
        data_in   = '0;
        index     = '0;
        res_valid = 1'b0;
        res_err   = 1'b0;
        res_data  = '0;
        case (state)
            S_RD_ISSUE: begin
                peek_en = 1'b1;
                index   = rd_index;
            end
            S_WR: begin
                case (op_q)
                    OP_PUSH: begin
                        push_en = 1'b1;
                        data_in = imm_q;
                    end
                    OP_DROP: pop_en = 1'b1;
                    OP_DUP, OP_OVER, OP_PICK: begin
                        push_en = 1'b1;
                        data_in = a_q;
                    end
                    OP_SWAP: begin
                        poke_en = 1'b1;
                        index   = IW'(k_q);
                        data_in = (k_q == 2'd0) ? b_q : a_q;
                    end
                    OP_ROT: begin
                        poke_en = 1'b1;
                        index   = IW'(k_q);
                        data_in = (k_q == 2'd0) ? c_q : ((k_q == 2'd1) ? a_q : b_q);
                    end
                    default: ;
                endcase
            end
            S_DONE: begin
                res_valid = 1'b1;
                res_err   = err_q;
                if (!err_q && op_has_result(op_q))
                    res_data = a_q;
            end
            default: ;
        endcase
    end

    assign st_push_en    = push_en;
    assign st_pop_en     = pop_en;
    assign st_peek_en    = peek_en;
    assign st_poke_en    = poke_en;
    assign st_data_in    = data_in;
    assign st_index      = index;

    assign cmd.cmd_ready = (state == S_IDLE);
    assign cmd.res_valid = res_valid;
    assign cmd.res_err   = res_err;
    assign cmd.res_data  = res_data;

endmodule
